cart_arb: RTL



---
 rtl/cart_arb_pkg.sv | 21 ++
 rtl/cart_arb_if.sv | 50 +++++
 rtl/cart_arb_port.sv | 51 +++++
 rtl/cart_arb.sv | 123 ++++++++++++
 4 files changed

// File: rtl/cart_arb_pkg.sv
// Shared types and constants for the two-master cartridge bus arbiter.
package cart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  typedef enum logic {
    DIR_RD = 1'b0,
    DIR_WR = 1'b1
  } dir_t;

  localparam int unsigned M_SPI = 0;
  localparam int unsigned M_SS  = 1;

  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned DATA_W_DEF = 8;

endpackage

// File: rtl/cart_arb_if.sv
// Bus bundle between the two masters, the arbiter and cart_iface.
// slave: arbiter view; master: the masters plus cart_iface view.
interface cart_arb_if
  import cart_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic [ADDR_W-1:0] m0_addr;
  logic              m0_rd;
  logic              m0_wr;
  logic [DATA_W-1:0] m0_wdata;
  logic [DATA_W-1:0] m0_rdata;
  logic              m0_busy;

  logic [ADDR_W-1:0] m1_addr;
  logic              m1_rd;
  logic              m1_wr;
  logic [DATA_W-1:0] m1_wdata;
  logic [DATA_W-1:0] m1_rdata;
  logic              m1_busy;

  logic [ADDR_W-1:0] c_addr;
  logic              c_rd;
  logic              c_wr;
  logic [DATA_W-1:0] c_din;
  logic [DATA_W-1:0] c_dout;
  logic              c_busy;
  logic              c_owner;

  modport slave (
    input  m0_addr, m0_rd, m0_wr, m0_wdata,
    output m0_rdata, m0_busy,
    input  m1_addr, m1_rd, m1_wr, m1_wdata,
    output m1_rdata, m1_busy,
    output c_addr, c_rd, c_wr, c_din, c_owner,
    input  c_dout, c_busy
  );

  modport master (
    output m0_addr, m0_rd, m0_wr, m0_wdata,
    input  m0_rdata, m0_busy,
    output m1_addr, m1_rd, m1_wr, m1_wdata,
    input  m1_rdata, m1_busy,
    input  c_addr, c_rd, c_wr, c_din, c_owner,
    output c_dout, c_busy
  );

endinterface

// File: rtl/cart_arb_port.sv
// Per-master request slot: strobe capture, pending addr/wdata/dir,
// busy flag and the master's read-data register.
module cart_arb_port
  import cart_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              done,
  input  logic              rdata_load,
  input  logic [DATA_W-1:0] rdata_in,
  output logic              pend,
  output logic [ADDR_W-1:0] pend_addr,
  output logic [DATA_W-1:0] pend_wdata,
  output dir_t              pend_dir,
  output logic [DATA_W-1:0] rdata,
  output logic              busy
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend       <= 1'b0;
      pend_addr  <= '0;
      pend_wdata <= '0;
      pend_dir   <= DIR_RD;
      rdata      <= '0;
    end else begin
      // Strobes arriving while a request is held are dropped; rd wins over wr.
      if (!pend && (rd || wr)) begin
        pend       <= 1'b1;
        pend_addr  <= addr;
        pend_wdata <= wdata;
        pend_dir   <= rd ? DIR_RD : DIR_WR;
      end else if (done) begin
        pend <= 1'b0;
      end
      if (rdata_load) begin
        rdata <= rdata_in;
      end
    end
  end

  assign busy = pend;

endmodule

// File: rtl/cart_arb.sv
// Two-master arbiter serialising spicart and startupscreen_gen onto cart_iface.
// Define CART_ARB_RR_EN for round-robin; default is fixed priority (master 0).
module cart_arb
  import cart_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input logic       clk_8m,
  input logic       rst_n,
  cart_arb_if.slave bus
);

  logic              pend0, pend1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  dir_t              dir0, dir1;

  state_t            state;
  dir_t              cur_dir;
  logic              first_wait;
  logic              win;
  logic              done, done0, done1;

  always_comb begin
    win = 1'b0;
`ifdef CART_ARB_RR_EN
    if (pend0 && pend1) begin
      win = ~bus.c_owner;
    end else begin
      win = pend1;
    end
`else
    win = !pend0;
`endif
  end

  // Completion: first non-busy WAIT cycle after the one we ignore.
  assign done  = (state == WAIT) && !first_wait && !bus.c_busy;
  assign done0 = done && (bus.c_owner == 1'(M_SPI));
  assign done1 = done && (bus.c_owner == 1'(M_SS));

  always_ff @(posedge clk_8m) begin
    if (!rst_n) begin
      state       <= IDLE;
      cur_dir     <= DIR_RD;
      first_wait  <= 1'b0;
      bus.c_addr  <= '0;
      bus.c_din   <= '0;
      bus.c_rd    <= 1'b0;
      bus.c_wr    <= 1'b0;
      bus.c_owner <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pend0 || pend1) begin
            bus.c_owner <= win;
            bus.c_addr  <= win ? addr1 : addr0;
            bus.c_din   <= win ? wdata1 : wdata0;
            cur_dir     <= win ? dir1 : dir0;
            bus.c_rd    <= (win ? dir1 : dir0) == DIR_RD;
            bus.c_wr    <= (win ? dir1 : dir0) == DIR_WR;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          bus.c_rd   <= 1'b0;
          bus.c_wr   <= 1'b0;
          first_wait <= 1'b1;
          state      <= WAIT;
        end
        WAIT: begin
          first_wait <= 1'b0;
          if (done) begin
            state <= IDLE;
          end
        end
        default: begin
          bus.c_rd <= 1'b0;
          bus.c_wr <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  cart_arb_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_port0 (
    .clk        (clk_8m),
    .rst_n      (rst_n),
    .rd         (bus.m0_rd),
    .wr         (bus.m0_wr),
    .addr       (bus.m0_addr),
    .wdata      (bus.m0_wdata),
    .done       (done0),
    .rdata_load (done0 && (cur_dir == DIR_RD)),
    .rdata_in   (bus.c_dout),
    .pend       (pend0),
    .pend_addr  (addr0),
    .pend_wdata (wdata0),
    .pend_dir   (dir0),
    .rdata      (bus.m0_rdata),
    .busy       (bus.m0_busy)
  );

  cart_arb_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_port1 (
    .clk        (clk_8m),
    .rst_n      (rst_n),
    .rd         (bus.m1_rd),
    .wr         (bus.m1_wr),
    .addr       (bus.m1_addr),
    .wdata      (bus.m1_wdata),
    .done       (done1),
    .rdata_load (done1 && (cur_dir == DIR_RD)),
    .rdata_in   (bus.c_dout),
    .pend       (pend1),
    .pend_addr  (addr1),
    .pend_wdata (wdata1),
    .pend_dir   (dir1),
    .rdata      (bus.m1_rdata),
    .busy       (bus.m1_busy)
  );

endmodule
